// File: rtl/instr_fetch_if.sv
// Fetch-to-decode payload: instruction word and its PC pair.
interface data_fetch_io;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] pc_plus4;

  // Fetch side drives the payload.
  modport in  (output instr, output pc, output pc_plus4);
  // Decode side consumes it.
  modport out (input instr, input pc, input pc_plus4);
endinterface

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, drives a 2-cycle BRAM and tags each in-flight
// fetch so that stalls freeze the stream and redirects squash wrong-path work.
module instr_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_f,
  input  logic              pc_src_e,
  input  logic [31:0]       pc_target_e,
  output logic              imem_en,
  output logic [31:0]       imem_addr,
  input  logic [31:0]       imem_rdata,
  data_fetch_io.in          data_fetch_if,
  output logic              valid_d,
  output logic [31:0]       fetch_count
);

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  logic [XLEN-1:0] pc_f;
  logic [XLEN-1:0] pc_1;
  logic [XLEN-1:0] pc_2;
  logic            v_1;
  logic            v_2;

  logic            advance_c;
  logic [XLEN-1:0] target_c;
  logic [XLEN-1:0] pc_out_c;
  logic            unused_target_lsbs;

  // Word-aligned redirect target; the low bits carry no meaning.
  assign target_c           = {pc_target_e[31:2], 2'b00};
  assign unused_target_lsbs = ^pc_target_e[1:0];

  // A redirect overrides a stall; reset freezes the BRAM.
  assign advance_c = ~rst & (~stall_f | pc_src_e);
  assign imem_en   = advance_c;
  assign imem_addr = pc_src_e ? target_c : pc_f;

  // Fetch pipeline: PC plus the tags that travel alongside the BRAM stages.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_f <= RESET_PC;
      pc_1 <= '0;
      pc_2 <= '0;
      v_1  <= 1'b0;
      v_2  <= 1'b0;
    end else if (advance_c) begin
      pc_1 <= imem_addr;
      v_1  <= 1'b1;
      pc_2 <= pc_1;
      // The fetch in stage 1 is wrong-path when a redirect arrives.
      v_2  <= v_1 & ~pc_src_e;
      pc_f <= imem_addr + PC_STEP;
    end
  end

  // Count instructions that decode actually consumes this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_count <= '0;
    end else if (v_2 & ~stall_f & ~pc_src_e) begin
      fetch_count <= fetch_count + XLEN'(1);
    end
  end

  // Decode-facing view; reset forces a clean bubble immediately.
  assign valid_d                = v_2 & ~rst;
  assign pc_out_c               = rst ? '0 : pc_2;
  assign data_fetch_if.instr    = valid_d ? imem_rdata : NOP_INSTR;
  assign data_fetch_if.pc       = pc_out_c;
  assign data_fetch_if.pc_plus4 = pc_out_c + PC_STEP;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios followed by random traffic,
// checked cycle by cycle against a fetch-history reference model.
module tb_instr_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_f;
  logic        pc_src_e;
  logic [31:0] pc_target_e;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        valid_d;
  logic [31:0] fetch_count;

  data_fetch_io dfi ();

  instr_fetch #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall_f      (stall_f),
    .pc_src_e     (pc_src_e),
    .pc_target_e  (pc_target_e),
    .imem_en      (imem_en),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .data_fetch_if(dfi),
    .valid_d      (valid_d),
    .fetch_count  (fetch_count)
  );

  always #5 clk = ~clk;

  // Program image: one fixed word from the test plan, hashed contents elsewhere.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'h0050_0093;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // BRAM: address register and output register share one enable.
  logic [31:0] bram_addr_q = '0;
  always @(posedge clk) begin
    if (imem_en) begin
      bram_addr_q <= imem_addr;
      imem_rdata  <= mem_word(bram_addr_q);
    end
  end

  // Reference model: history of issued fetches; decode shows the one issued
  // two advancing cycles ago, unless a redirect killed it.
  typedef struct {
    logic [31:0] pc;
    logic        live;
  } fetch_t;

  typedef struct {
    logic        en;
    logic        addr_chk;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] instr;
    logic        pc_chk;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] cnt;
  } exp_t;

  fetch_t      hist[$];
  logic [31:0] seq_pc;
  logic [31:0] cnt_m;
  exp_t        expq[$];

  int checks   = 0;
  int failures = 0;

  function automatic fetch_t at_decode();
    fetch_t f;
    f.pc = 32'h0; f.live = 1'b0;
    if (hist.size() == 2) f = hist[0];
    return f;
  endfunction

  task automatic model_reset();
    hist.delete();
    seq_pc = RST_PC;
    cnt_m  = '0;
  endtask

  task automatic model_edge(input logic r, input logic s, input logic p, input logic [31:0] t);
    fetch_t d, e, n;
    logic [31:0] tgt;
    if (r) begin
      model_reset();
    end else begin
      d = at_decode();
      if (d.live && !s && !p) cnt_m = cnt_m + 32'd1;
      if (!s || p) begin
        tgt = t;
        tgt[1:0] = 2'b00;
        n.pc   = p ? tgt : seq_pc;
        n.live = 1'b1;
        if (p && hist.size() > 0) begin
          e = hist.pop_back();
          e.live = 1'b0;
          hist.push_back(e);
        end
        hist.push_back(n);
        if (hist.size() > 2) void'(hist.pop_front());
        seq_pc = n.pc + 32'd4;
      end
    end
  endtask

  function automatic exp_t expect_now(input logic r, input logic s, input logic p, input logic [31:0] t);
    exp_t x;
    fetch_t d;
    logic [31:0] tgt;
    tgt = t;
    tgt[1:0] = 2'b00;
    x.cnt = cnt_m;
    if (r) begin
      x.en = 1'b0; x.addr_chk = 1'b0; x.addr = '0;
      x.valid = 1'b0; x.instr = NOP;
      x.pc_chk = 1'b1; x.pc = 32'h0; x.pc4 = 32'h4;
    end else begin
      d = at_decode();
      x.en       = !s || p;
      x.addr_chk = x.en;
      x.addr     = p ? tgt : seq_pc;
      x.valid    = d.live;
      x.instr    = d.live ? mem_word(d.pc) : NOP;
      x.pc_chk   = d.live;
      x.pc       = d.pc;
      x.pc4      = d.pc + 32'd4;
    end
    return x;
  endfunction

  task automatic step(input logic r, input logic s, input logic p, input logic [31:0] t);
    rst = r; stall_f = s; pc_src_e = p; pc_target_e = t;
    expq.push_back(expect_now(r, s, p, t));
    @(posedge clk);
    model_edge(r, s, p, t);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: compare DUT outputs against the expectation queued for this cycle.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        x = expq.pop_front();
        chk("imem_en", 32'(imem_en), 32'(x.en));
        if (x.addr_chk) chk("imem_addr", imem_addr, x.addr);
        chk("valid_d", 32'(valid_d), 32'(x.valid));
        chk("instr", dfi.instr, x.instr);
        if (x.pc_chk) begin
          chk("pc", dfi.pc, x.pc);
          chk("pc_plus4", dfi.pc_plus4, x.pc4);
        end
        chk("fetch_count", fetch_count, x.cnt);
      end
    end
  end

  // Stimulus: test-plan scenarios, then randomized traffic.
  initial begin
    logic        r, s, p;
    logic [31:0] t;
    rst = 1'b1; stall_f = 1'b0; pc_src_e = 1'b0; pc_target_e = '0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();

    step(1, 0, 0, 0);
    repeat (4) step(0, 0, 0, 0);           // cycles 0..3, 0x108 reaches decode at 4
    repeat (3) step(0, 1, 0, 0);           // 3-cycle stall holding 0x108
    step(0, 0, 0, 0);
    step(0, 0, 1, 32'h0000_0203);          // redirect while 0x10C at decode
    repeat (2) step(0, 0, 0, 0);
    step(0, 1, 1, 32'h0000_0203);          // redirect coincident with stall
    repeat (3) step(0, 0, 0, 0);
    step(0, 0, 1, 32'h0000_0300);          // back-to-back redirects
    step(0, 0, 1, 32'h0000_0400);
    repeat (8) step(0, 0, 0, 0);
    repeat (2) step(1, 0, 0, 0);           // mid-stream reset
    repeat (6) step(0, 0, 0, 0);
    step(0, 0, 1, 32'hFFFF_FFF9);          // wrap through the top of memory
    repeat (5) step(0, 0, 0, 0);

    for (int i = 0; i < 600; i++) begin
      r = ($urandom_range(0, 99) < 2);
      s = ($urandom_range(0, 99) < 25);
      p = ($urandom_range(0, 99) < 15);
      t = ($urandom_range(0, 9) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      step(r, s, p, t);
    end
    step(0, 0, 0, 0);

    @(negedge clk);
    #1;
    checks++;
    if (expq.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d required=0", expq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
